// File: rtl/kbd_source_arbiter_pkg.sv
// Shared definitions for the Apple-1 keyboard source arbiter.
//   SRC_UART / SRC_PS2     : source identifiers (kbd_src, round-robin memory)
//   ASCII_CR / ASCII_RUBOUT: normalised replacement codes
//   kbd_state_t            : output register FSM states
package kbd_source_arbiter_pkg;

    localparam logic       SRC_UART     = 1'b0;
    localparam logic       SRC_PS2      = 1'b1;
    localparam logic [6:0] ASCII_CR     = 7'h0D;
    localparam logic [6:0] ASCII_RUBOUT = 7'h5F;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } kbd_state_t;

endpackage

// File: rtl/kbd_source_arbiter_fifo.sv
// Synchronous per-source character FIFO.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push/i_din : write request and data
//   i_pop        : read request (head advances)
//   i_flush      : synchronous clear, overrides push/pop
//   o_dout       : head entry (valid when !o_empty)
//   o_full/o_empty
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module kbd_source_arbiter_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A full FIFO still accepts a write when the head is popped in the same
    // cycle: the slot being written is the one being vacated.
    assign w_wr_en = i_push && (!o_full || i_pop) && !i_flush;
    assign w_rd_en = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/kbd_source_arbiter.sv
// Apple-1 keyboard source arbiter: merges UART RX bytes and PS/2 ASCII into
// the PIA keyboard register (KBD/KBDCR).
// Ports:
//   clk25, rst_n            : 25 MHz clock, asynchronous active-low reset
//   uart_data/uart_valid    : UART byte + 1-cycle strobe
//   ps2_data/ps2_valid      : PS/2 ASCII byte + 1-cycle strobe
//   src_en[1:0]             : [0]=UART, [1]=PS/2 accept enables
//   flush                   : synchronous clear of FIFOs, KBD and overflow
//   kbd_read                : CPU read strobe of KBD
//   kbd_data/kbd_ready/kbd_src : presented character, KBDCR bit7, its source
//   overflow[1:0]           : sticky per-source FIFO overflow
module kbd_source_arbiter
    import kbd_source_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic [7:0] uart_data,
    input  logic       uart_valid,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    input  logic [1:0] src_en,
    input  logic       flush,
    input  logic       kbd_read,
    output logic [6:0] kbd_data,
    output logic       kbd_ready,
    output logic       kbd_src,
    output logic [1:0] overflow
);

    // Apple-1 only understands upper-case 7-bit ASCII, CR as newline and '_'
    // as rubout.
    function automatic logic [6:0] normalise(input logic [7:0] b);
        logic [7:0] c;
        c = b & 8'h7F;
        if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
        else if (c == 8'h0A)          c = {1'b0, ASCII_CR};
        else if (c == 8'h08 || c == 8'h7F) c = {1'b0, ASCII_RUBOUT};
        return c[6:0];
    endfunction

    kbd_state_t r_state, w_state_nxt;
    logic       r_rr_last;
    logic [6:0] r_kbd_data;
    logic       r_kbd_src;
    logic [1:0] r_overflow;

    logic       w_u_req, w_p_req;
    logic       w_u_pop, w_p_pop;
    logic       w_u_full, w_p_full;
    logic       w_u_empty, w_p_empty;
    logic [6:0] w_u_dout, w_p_dout;

    assign w_u_req = uart_valid && src_en[0];
    assign w_p_req = ps2_valid  && src_en[1];

    kbd_source_arbiter_fifo #(.WIDTH(7), .DEPTH(FIFO_DEPTH)) u_fifo_uart (
        .clk     (clk25),
        .rst_n   (rst_n),
        .i_push  (w_u_req),
        .i_din   (normalise(uart_data)),
        .i_pop   (w_u_pop),
        .i_flush (flush),
        .o_dout  (w_u_dout),
        .o_full  (w_u_full),
        .o_empty (w_u_empty)
    );

    kbd_source_arbiter_fifo #(.WIDTH(7), .DEPTH(FIFO_DEPTH)) u_fifo_ps2 (
        .clk     (clk25),
        .rst_n   (rst_n),
        .i_push  (w_p_req),
        .i_din   (normalise(ps2_data)),
        .i_pop   (w_p_pop),
        .i_flush (flush),
        .o_dout  (w_p_dout),
        .o_full  (w_p_full),
        .o_empty (w_p_empty)
    );

    // Grant goes to the only non-empty FIFO, or to the source that did not
    // win last time when both hold data. Reload happens only from S_EMPTY so
    // ready is low for at least one cycle between characters.
    always_comb begin
        w_state_nxt = r_state;
        w_u_pop     = 1'b0;
        w_p_pop     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (!w_u_empty && (w_p_empty || r_rr_last == SRC_PS2)) begin
                    w_u_pop     = 1'b1;
                    w_state_nxt = S_FULL;
                end else if (!w_p_empty) begin
                    w_p_pop     = 1'b1;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (kbd_read) w_state_nxt = S_EMPTY;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_u_pop     = 1'b0;
            w_p_pop     = 1'b0;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_rr_last  <= SRC_PS2;
            r_kbd_data <= '0;
            r_kbd_src  <= SRC_UART;
            r_overflow <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_kbd_data <= '0;
                r_kbd_src  <= SRC_UART;
                r_overflow <= '0;
            end else begin
                if (w_u_pop || w_p_pop) begin
                    r_kbd_data <= w_u_pop ? w_u_dout : w_p_dout;
                    r_kbd_src  <= w_p_pop ? SRC_PS2 : SRC_UART;
                    r_rr_last  <= w_p_pop ? SRC_PS2 : SRC_UART;
                end
                // A write to a full FIFO that is popped this cycle is not lost.
                r_overflow[0] <= r_overflow[0] | (w_u_req & w_u_full & ~w_u_pop);
                r_overflow[1] <= r_overflow[1] | (w_p_req & w_p_full & ~w_p_pop);
            end
        end
    end

    assign kbd_ready = (r_state == S_FULL);
    assign kbd_data  = r_kbd_data;
    assign kbd_src   = r_kbd_src;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_kbd_source_arbiter.sv
module tb_kbd_source_arbiter;

    localparam int D = 4;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] uart_data = '0;
    logic       uart_valid = 1'b0;
    logic [7:0] ps2_data = '0;
    logic       ps2_valid = 1'b0;
    logic [1:0] src_en = 2'b11;
    logic       flush = 1'b0;
    logic       kbd_read = 1'b0;
    logic [6:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_src;
    logic [1:0] overflow;

    always #20 clk25 = ~clk25;

    kbd_source_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .ps2_data   (ps2_data),
        .ps2_valid  (ps2_valid),
        .src_en     (src_en),
        .flush      (flush),
        .kbd_read   (kbd_read),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .kbd_src    (kbd_src),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: two character queues plus the visible KBD register.
    logic [6:0] uq[$];
    logic [6:0] pq[$];
    logic       m_ready;
    logic [6:0] m_data;
    logic       m_src;
    logic [1:0] m_ovf;
    logic       m_rr;

    function automatic logic [6:0] ref_norm(input logic [7:0] b);
        int v;
        v = int'(b) % 128;
        if (v >= 'h61 && v <= 'h7A) v = v - 32;
        else if (v == 'h0A) v = 'h0D;
        else if (v == 'h08 || v == 'h7F) v = 'h5F;
        return v[6:0];
    endfunction

    task automatic model_reset();
        uq.delete();
        pq.delete();
        m_ready = 0; m_data = 0; m_src = 0; m_ovf = 0; m_rr = 1;
    endtask

    task automatic model_step(input logic uv, input logic [7:0] ud, input logic pv,
                              input logic [7:0] pd, input logic rd, input logic fl);
        int  usz, psz;
        bit  upop, ppop;
        usz = uq.size(); psz = pq.size(); upop = 0; ppop = 0;
        if (fl) begin
            uq.delete(); pq.delete();
            m_ready = 0; m_data = 0; m_src = 0; m_ovf = 0;
            return;
        end
        if (!m_ready) begin
            if (usz > 0 && (psz == 0 || m_rr == 1)) begin
                m_data = uq.pop_front(); m_src = 0; upop = 1;
            end else if (psz > 0) begin
                m_data = pq.pop_front(); m_src = 1; ppop = 1;
            end
            if (upop || ppop) begin m_ready = 1; m_rr = m_src; end
        end else if (rd) begin
            m_ready = 0;
        end
        if (uv && src_en[0]) begin
            if (usz == D && !upop) m_ovf[0] = 1'b1;
            else uq.push_back(ref_norm(ud));
        end
        if (pv && src_en[1]) begin
            if (psz == D && !ppop) m_ovf[1] = 1'b1;
            else pq.push_back(ref_norm(pd));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance model, sample #1 later.
    task automatic cycle(input logic uv, input logic [7:0] ud, input logic pv,
                         input logic [7:0] pd, input logic rd, input logic fl);
        uart_valid = uv; uart_data = ud; ps2_valid = pv; ps2_data = pd;
        kbd_read = rd; flush = fl;
        @(posedge clk25);
        model_step(uv, ud, pv, pd, rd, fl);
        #1;
        uart_valid = 0; ps2_valid = 0; kbd_read = 0; flush = 0;
    endtask

    task automatic idle();
        cycle(0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        if ({kbd_ready, kbd_src, kbd_data, overflow} !== 11'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", {kbd_ready, kbd_src, kbd_data, overflow}, 11'h0);
        end
        checks++;
        model_reset();
        #25 rst_n = 1'b1;
        idle();
        if (kbd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_idle_ready: got %b expected 0", kbd_ready);
        end
        checks++;
    endtask

    task automatic test_latency();
        src_en = 2'b11;
        cycle(1, 8'h61, 0, 8'h00, 0, 0);
        if (kbd_ready !== 1'b0) begin
            errors++; $display("FAIL latency_edge1_ready: got %b expected 0", kbd_ready);
        end
        checks++;
        idle();
        if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b0, 7'h41}) begin
            errors++; $display("FAIL latency_char: got %h expected %h", {kbd_ready, kbd_src, kbd_data}, {1'b1, 1'b0, 7'h41});
        end
        checks++;
        cycle(0, 8'h00, 0, 8'h00, 1, 0);
        if ({kbd_ready, kbd_src, kbd_data, overflow} !== {m_ready, m_src, m_data, m_ovf}) begin
            errors++; $display("FAIL latency_model: got %h expected %h", {kbd_ready, kbd_src, kbd_data, overflow}, {m_ready, m_src, m_data, m_ovf});
        end
        checks++;
    endtask

    task automatic test_rubout();
        cycle(0, 8'h00, 1, 8'h7F, 0, 0);
        idle();
        if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b1, 7'h5F}) begin
            errors++; $display("FAIL rubout_char: got %h expected %h", {kbd_ready, kbd_src, kbd_data}, {1'b1, 1'b1, 7'h5F});
        end
        checks++;
        cycle(0, 8'h00, 0, 8'h00, 1, 0);
        if (kbd_ready !== 1'b0) begin
            errors++; $display("FAIL rubout_ready_drop: got %b expected 0", kbd_ready);
        end
        checks++;
        idle(); idle();
        if (kbd_ready !== 1'b0) begin
            errors++; $display("FAIL rubout_ready_stays_low: got %b expected 0", kbd_ready);
        end
        checks++;
    endtask

    task automatic test_alternate();
        logic [6:0] seq [4];
        seq[0] = 7'h58; seq[1] = 7'h59; seq[2] = 7'h58; seq[3] = 7'h59;
        cycle(1, 8'h58, 1, 8'h59, 0, 0);
        cycle(1, 8'h58, 1, 8'h59, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if ({kbd_ready, kbd_data} !== {1'b1, seq[k]} ||
                {kbd_ready, kbd_src, kbd_data} !== {m_ready, m_src, m_data}) begin
                errors++; $display("FAIL alternate_char%0d: got %h expected %h", k, {kbd_ready, kbd_src, kbd_data}, {1'b1, k[0], seq[k]});
            end
            checks++;
            cycle(0, 8'h00, 0, 8'h00, 1, 0);
            if (kbd_ready !== 1'b0) begin
                errors++; $display("FAIL alternate_gap%0d: got %b expected 0", k, kbd_ready);
            end
            checks++;
            idle();
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 6; k++) cycle(0, 8'h00, 1, 8'h41 + 8'(k), 0, 0);
        if ({kbd_ready, kbd_data, overflow} !== {1'b1, 7'h41, 2'b10}) begin
            errors++; $display("FAIL overflow_set: got %h expected %h", {kbd_ready, kbd_data, overflow}, {1'b1, 7'h41, 2'b10});
        end
        checks++;
        for (int k = 0; k < 5; k++) begin
            if ({kbd_ready, kbd_data} !== {1'b1, 7'h41 + 7'(k)}) begin
                errors++; $display("FAIL overflow_read%0d: got %h expected %h", k, {kbd_ready, kbd_data}, {1'b1, 7'h41 + 7'(k)});
            end
            checks++;
            cycle(0, 8'h00, 0, 8'h00, 1, 0);
            idle();
        end
        if ({kbd_ready, overflow} !== {1'b0, 2'b10}) begin
            errors++; $display("FAIL overflow_drained: got %h expected %h", {kbd_ready, overflow}, {1'b0, 2'b10});
        end
        checks++;
    endtask

    task automatic test_src_en();
        src_en = 2'b01;
        cycle(0, 8'h00, 1, 8'h51, 0, 0);
        idle(); idle();
        if ({kbd_ready, overflow} !== {1'b0, 2'b10}) begin
            errors++; $display("FAIL src_en_ignored: got %h expected %h", {kbd_ready, overflow}, {1'b0, 2'b10});
        end
        checks++;
        cycle(1, 8'h0A, 0, 8'h00, 0, 0);
        idle();
        if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b0, 7'h0D}) begin
            errors++; $display("FAIL src_en_lf_to_cr: got %h expected %h", {kbd_ready, kbd_src, kbd_data}, {1'b1, 1'b0, 7'h0D});
        end
        checks++;
        cycle(0, 8'h00, 0, 8'h00, 1, 0);
        src_en = 2'b11;
    endtask

    task automatic test_flush();
        cycle(1, 8'h61, 1, 8'h63, 0, 0);
        cycle(1, 8'h62, 0, 8'h00, 0, 0);
        idle();
        cycle(0, 8'h00, 0, 8'h00, 1, 1);
        if ({kbd_ready, kbd_data, overflow} !== 10'h0) begin
            errors++; $display("FAIL flush_clear: got %h expected %h", {kbd_ready, kbd_data, overflow}, 10'h0);
        end
        checks++;
        idle(); idle();
        if ({kbd_ready, kbd_src, kbd_data, overflow} !== {m_ready, m_src, m_data, m_ovf} || kbd_ready !== 1'b0) begin
            errors++; $display("FAIL flush_fifos_empty: got %h expected %h", {kbd_ready, kbd_src, kbd_data, overflow}, {m_ready, m_src, m_data, m_ovf});
        end
        checks++;
    endtask

    task automatic test_async_reset();
        cycle(1, 8'h31, 1, 8'h32, 0, 0);
        cycle(1, 8'h33, 1, 8'h34, 0, 0);
        #5 rst_n = 1'b0;
        #1;
        if ({kbd_ready, kbd_src, kbd_data, overflow} !== 11'h0) begin
            errors++; $display("FAIL async_reset_outputs: got %h expected %h", {kbd_ready, kbd_src, kbd_data, overflow}, 11'h0);
        end
        checks++;
        model_reset();
        #5 rst_n = 1'b1;
        idle(); idle();
        if (kbd_ready !== 1'b0) begin
            errors++; $display("FAIL async_reset_bytes_lost: got %b expected 0", kbd_ready);
        end
        checks++;
    endtask

    task automatic test_random();
        logic uv, pv, rd, fl;
        for (int n = 0; n < 800; n++) begin
            if (n % 64 == 0) src_en = 2'($urandom_range(0, 3));
            uv = ($urandom_range(0, 2) == 0);
            pv = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 99) == 0);
            cycle(uv, 8'($urandom), pv, 8'($urandom), rd, fl);
            if ({kbd_ready, kbd_src, kbd_data, overflow} !== {m_ready, m_src, m_data, m_ovf}) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", n, {kbd_ready, kbd_src, kbd_data, overflow}, {m_ready, m_src, m_data, m_ovf});
            end
            checks++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_rubout();
        test_alternate();
        test_overflow();
        test_src_en();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
